// File: rtl/simon_pkg.sv
// Shared Simon 32/64 constants, types and rotate helpers.
// Used by the key expander and the encryption datapath.
package simon_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned KEY_WORDS = 4;
    localparam int unsigned ROUNDS    = 32;
    localparam int unsigned IDX_W     = $clog2(ROUNDS);

    localparam logic [WORD_W-1:0] SIMON_C = 16'hFFFC;
    localparam logic [61:0]       Z0      = 62'b11111010001001010110000111001101111101000100101011000011100110;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t ror1(input word_t x);
        return {x[0], x[WORD_W-1:1]};
    endfunction

    function automatic word_t ror3(input word_t x);
        return {x[2:0], x[WORD_W-1:3]};
    endfunction

    // z0[j] counts from the leftmost bit of the literal, i.e. Z0[61-j].
    function automatic logic z0_bit(input logic [IDX_W-1:0] j);
        logic [5:0] pos;
        pos = 6'd61 - {1'b0, j};
        return Z0[pos];
    endfunction

endpackage

// File: rtl/simon_key_step.sv
// One Simon 32/64 key-schedule step: k[i] from k[i-4], k[i-3], k[i-1] and the z bit.
module simon_key_step
    import simon_pkg::*;
(
    input  logic [WORD_W-1:0] k_im4,
    input  logic [WORD_W-1:0] k_im3,
    input  logic [WORD_W-1:0] k_im1,
    input  logic              z,
    output logic [WORD_W-1:0] k_i
);

    word_t tmp_a;
    word_t tmp_b;

    always_comb begin
        tmp_a = ror3(k_im1) ^ k_im3;
        tmp_b = tmp_a ^ ror1(tmp_a);
        k_i   = SIMON_C ^ {{(WORD_W-1){1'b0}}, z} ^ k_im4 ^ tmp_b;
    end

endmodule

// File: rtl/simon_key_expander.sv
// Iterative Simon 32/64 key expansion: one subkey per clock into a 32x16
// register file, served through a registered read port.
module simon_key_expander
    import simon_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_W*KEY_WORDS-1:0]   key,
    input  logic                          load_key,
    output logic                          key_ready,
    output logic                          busy,
    output logic                          sched_done,
    input  logic [IDX_W-1:0]              sk_addr,
    output logic [WORD_W-1:0]             sk_out
);

    localparam int unsigned         WIN_W     = $clog2(KEY_WORDS);
    localparam logic [IDX_W-1:0]    FIRST_GEN = IDX_W'(KEY_WORDS);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(ROUNDS - 1);

    state_t           state;
    word_t            storage [ROUNDS];
    word_t            win [KEY_WORDS];
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] z_idx;
    logic             z_cur;
    word_t            k_next;

    always_comb begin
        z_idx = idx - FIRST_GEN;
        z_cur = z0_bit(z_idx);
    end

    // Window holds k[i-4]..k[i-1], oldest in slot 0.
    simon_key_step u_step (
        .k_im4 (win[0]),
        .k_im3 (win[1]),
        .k_im1 (win[KEY_WORDS-1]),
        .z     (z_cur),
        .k_i   (k_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            sched_done <= 1'b0;
            sk_out     <= '0;
            idx        <= '0;
            for (int unsigned i = 0; i < ROUNDS; i++) begin
                storage[IDX_W'(i)] <= '0;
            end
            for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                win[WIN_W'(i)] <= '0;
            end
        end else begin
            // Read is sampled before any write lands, giving read-before-write.
            sk_out <= storage[sk_addr];

            if (load_key) begin
                for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                    storage[IDX_W'(i)] <= key[i*WORD_W +: WORD_W];
                    win[WIN_W'(i)]     <= key[i*WORD_W +: WORD_W];
                end
                idx        <= FIRST_GEN;
                state      <= EXPAND;
                busy       <= 1'b1;
                key_ready  <= 1'b0;
                sched_done <= 1'b0;
            end else begin
                case (state)
                    EXPAND: begin
                        storage[idx] <= k_next;
                        for (int unsigned i = 0; i < KEY_WORDS - 1; i++) begin
                            win[WIN_W'(i)] <= win[WIN_W'(i + 1)];
                        end
                        win[KEY_WORDS-1] <= k_next;
                        idx              <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            key_ready  <= 1'b1;
                            sched_done <= 1'b1;
                        end
                    end
                    IDLE: begin
                    end
                    DONE: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_key_expander.sv
// Scoreboard bench for simon_key_expander against a software Simon 32/64 key schedule.
module tb_simon_key_expander;

    typedef logic [15:0] sched_t [32];

    typedef struct {
        int          due;
        string       name;
        bit          chk_sk;
        logic [15:0] sk;
        bit          chk_fl;
        logic [2:0]  fl;
    } exp_t;

    // {key_ready, busy, sched_done}
    localparam logic [2:0] IDLE_FL = 3'b100;
    localparam logic [2:0] BUSY_FL = 3'b010;
    localparam logic [2:0] DONE_FL = 3'b101;

    localparam logic [61:0] ZSEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] key;
    logic        load_key;
    logic        key_ready;
    logic        busy;
    logic        sched_done;
    logic [4:0]  sk_addr;
    logic [15:0] sk_out;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simon_key_expander dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .load_key   (load_key),
        .key_ready  (key_ready),
        .busy       (busy),
        .sched_done (sched_done),
        .sk_addr    (sk_addr),
        .sk_out     (sk_out)
    );

    function automatic logic [15:0] rr(input logic [15:0] x, input int r);
        return (x >> r) | (x << (16 - r));
    endfunction

    task automatic ref_sched(input logic [63:0] k, output sched_t s);
        logic [15:0] t;
        logic [5:0]  pos;
        for (int i = 0; i < 4; i++) s[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            t   = rr(s[i-1], 3) ^ s[i-3];
            t   = t ^ rr(t, 1);
            pos = 6'(61 - (i - 4));
            s[i] = ~s[i-4] ^ t ^ {15'b0, ZSEQ[pos]} ^ 16'd3;
        end
    endtask

    task automatic expect_fl(input string n, input int due, input logic [2:0] fl);
        exp_t e;
        e = '{due: due, name: n, chk_sk: 1'b0, sk: 16'h0, chk_fl: 1'b1, fl: fl};
        sb.push_back(e);
    endtask

    task automatic expect_sk(input string n, input int due, input logic [15:0] v);
        exp_t e;
        e = '{due: due, name: n, chk_sk: 1'b1, sk: v, chk_fl: 1'b0, fl: 3'b000};
        sb.push_back(e);
    endtask

    // Monitor: compares every scoreboard entry on the cycle it falls due.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                if (sb[i].due < cyc) begin
                    checks++; errors++;
                    $display("FAIL %s: check due at cycle %0d missed (now %0d)", sb[i].name, sb[i].due, cyc);
                end else begin
                    if (sb[i].chk_fl) begin
                        checks++;
                        if ({key_ready, busy, sched_done} !== sb[i].fl) begin
                            errors++;
                            $display("FAIL %s flags @%0d: got ready/busy/done=%b want %b",
                                     sb[i].name, cyc, {key_ready, busy, sched_done}, sb[i].fl);
                        end
                    end
                    if (sb[i].chk_sk) begin
                        checks++;
                        if (sk_out !== sb[i].sk) begin
                            errors++;
                            $display("FAIL %s sk_out @%0d: got %h want %h", sb[i].name, cyc, sk_out, sb[i].sk);
                        end
                    end
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic do_load(input logic [63:0] k, output int t);
        @(negedge clk);
        key      = k;
        load_key = 1'b1;
        t        = cyc + 1;
        expect_fl("load", t, BUSY_FL);
    endtask

    task automatic advance_busy(input int edge_e, input string n);
        while (cyc + 1 < edge_e) begin
            @(negedge clk);
            load_key = 1'b0;
            expect_fl(n, cyc + 1, BUSY_FL);
        end
    endtask

    task automatic run_until_done(input int t, input string n);
        int due;
        due = 0;
        while (due < t + 28) begin
            @(negedge clk);
            load_key = 1'b0;
            due      = cyc + 1;
            expect_fl(n, due, (due == t + 28) ? DONE_FL : BUSY_FL);
        end
    endtask

    task automatic check_sched(input sched_t s, input string n);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            sk_addr = 5'(a);
            expect_sk(n, cyc + 1, s[a]);
            expect_fl(n, cyc + 1, DONE_FL);
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string n);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            sk_addr = 5'(a);
            expect_sk(n, cyc + 1, 16'h0000);
            expect_fl(n, cyc + 1, IDLE_FL);
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sched_t      s;
        sched_t      old;
        logic [15:0] kat [6];
        logic [63:0] k;
        int          t;
        int          t2;

        kat[0] = 16'h0100; kat[1] = 16'h0908; kat[2] = 16'h1110;
        kat[3] = 16'h1918; kat[4] = 16'h71C3; kat[5] = 16'hB649;

        rst = 1'b1; load_key = 1'b0; key = '0; sk_addr = '0;

        // Reset then idle
        @(negedge clk);
        expect_fl("reset", cyc + 1, IDLE_FL);
        expect_sk("reset_sk", cyc + 1, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset_mem");

        // Reference vector
        k = 64'h1918_1110_0908_0100;
        do_load(k, t);
        run_until_done(t, "ref_done");
        for (int a = 0; a < 6; a++) begin
            @(negedge clk);
            sk_addr = 5'(a);
            expect_sk("ref_kat", cyc + 1, kat[a]);
        end
        ref_sched(k, s);
        check_sched(s, "ref_sched");

        // Reload from DONE, reading addresses being overwritten on the same edge
        old = s;
        k   = {$urandom, $urandom};
        @(negedge clk);
        key = k; load_key = 1'b1; sk_addr = 5'd0;
        t = cyc + 1;
        expect_fl("reload", t, BUSY_FL);
        expect_sk("rbw_k0", t, old[0]);
        @(negedge clk);
        load_key = 1'b0; sk_addr = 5'd4;
        expect_fl("reload", t + 1, BUSY_FL);
        expect_sk("rbw_k4", t + 1, old[4]);
        run_until_done(t, "reload_done");
        ref_sched(k, s);
        check_sched(s, "reload_sched");

        // Abort mid-expansion with the all-zero key
        k = {$urandom, $urandom};
        do_load(k, t);
        advance_busy(t + 10, "abort_busy");
        do_load(64'h0, t2);
        run_until_done(t2, "abort_done");
        @(negedge clk);
        sk_addr = 5'd4;
        expect_sk("zero_k4", cyc + 1, 16'hFFFD);
        ref_sched(64'h0, s);
        check_sched(s, "abort_sched");

        // Reset mid-expansion
        k = {$urandom, $urandom};
        do_load(k, t);
        advance_busy(t + 15, "rst_busy");
        @(negedge clk);
        load_key = 1'b0; rst = 1'b1; sk_addr = 5'd0;
        expect_fl("mid_reset", cyc + 1, IDLE_FL);
        expect_sk("mid_reset_sk", cyc + 1, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        check_zero("mid_reset_mem");
        k = {$urandom, $urandom};
        do_load(k, t);
        run_until_done(t, "post_rst_done");
        ref_sched(k, s);
        check_sched(s, "post_rst_sched");

        // load_key held for 5 cycles
        k = {$urandom, $urandom};
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            key = k; load_key = 1'b1;
            t = cyc + 1;
            expect_fl("held_load", t, BUSY_FL);
        end
        run_until_done(t, "held_done");
        ref_sched(k, s);
        check_sched(s, "held_sched");

        // Random keys back to back
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom};
            do_load(k, t);
            run_until_done(t, "rand_done");
            ref_sched(k, s);
            check_sched(s, "rand_sched");
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
